// File: rtl/microwave_pkg.sv
// Shared digit type and constants for the microwave M:SS countdown timer.
package microwave_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t SECS_WRAP = 4'd9;
    localparam bcd_t TENS_WRAP = 4'd5;
    localparam bcd_t MINS_WRAP = 4'd9;
    localparam bcd_t DIGIT_MAX = 4'd9;

    function automatic bcd_t clamp_digit(input bcd_t d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clear, parallel load, borrow chain
// and a programmable wrap value loaded when it borrows from zero.
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter bcd_t WRAP = 4'd9
) (
    input  logic clk,
    input  logic clear,
    input  logic load,
    input  bcd_t load_val,
    input  logic borrow_in,
    output bcd_t value,
    output logic borrow_out,
    output logic zero
);

    assign zero       = (value == '0);
    assign borrow_out = borrow_in & zero;

    always_ff @(posedge clk) begin
        if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (borrow_in) begin
            value <= zero ? WRAP : value - 4'd1;
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Three-digit M:SS countdown: keypad shift-load, 1 Hz BCD countdown,
// and a done flag while the display reads 0:00.
module microwave_timer
    import microwave_pkg::*;
(
    input  logic       CLK,
    input  logic       clear,
    input  logic [3:0] digit,
    input  logic       enable,
    input  logic       loadn,
    output logic [3:0] minutes,
    output logic [3:0] tens_secs,
    output logic [3:0] secs,
    output logic       timer_done
);

    logic load;
    logic all_zero;
    logic count;
    logic secs_zero;
    logic tens_zero;
    logic mins_zero;
    logic secs_borrow;
    logic tens_borrow;
    logic underflow;
    bcd_t digit_in;

    assign load     = ~loadn;
    assign digit_in = clamp_digit(digit);
    assign all_zero = secs_zero & tens_zero & mins_zero;

    // Gating on all_zero keeps 0:00 sticky instead of wrapping to 9:59.
    assign count = loadn & enable & ~all_zero;

    bcd_down_digit #(.WRAP(SECS_WRAP)) u_secs (
        .clk       (CLK),
        .clear     (clear),
        .load      (load),
        .load_val  (digit_in),
        .borrow_in (count),
        .value     (secs),
        .borrow_out(secs_borrow),
        .zero      (secs_zero)
    );

    bcd_down_digit #(.WRAP(TENS_WRAP)) u_tens (
        .clk       (CLK),
        .clear     (clear),
        .load      (load),
        .load_val  (secs),
        .borrow_in (secs_borrow),
        .value     (tens_secs),
        .borrow_out(tens_borrow),
        .zero      (tens_zero)
    );

    bcd_down_digit #(.WRAP(MINS_WRAP)) u_mins (
        .clk       (CLK),
        .clear     (clear),
        .load      (load),
        .load_val  (tens_secs),
        .borrow_in (tens_borrow),
        .value     (minutes),
        .borrow_out(underflow),
        .zero      (mins_zero)
    );

    assign timer_done = all_zero;

    // A borrow out of the minutes digit would mean counting below 0:00.
    always_comb begin
        assert (!underflow);
    end

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with a digit-rule model checked
// every cycle after the first clear, plus literal expectations.
module tb_microwave_timer;

    logic       CLK = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       enable = 1'b0;
    logic       loadn = 1'b1;
    logic [3:0] minutes;
    logic [3:0] tens_secs;
    logic [3:0] secs;
    logic       timer_done;

    int checks = 0;
    int errors = 0;

    int  m_m = 0;
    int  m_t = 0;
    int  m_s = 0;
    bit  m_valid = 1'b0;

    always #5 CLK = ~CLK;

    microwave_timer dut (
        .CLK       (CLK),
        .clear     (clear),
        .digit     (digit),
        .enable    (enable),
        .loadn     (loadn),
        .minutes   (minutes),
        .tens_secs (tens_secs),
        .secs      (secs),
        .timer_done(timer_done)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Model: spec rules on three integer digits, evaluated per edge.
    always @(posedge CLK) begin
        if (clear) begin
            m_m = 0;
            m_t = 0;
            m_s = 0;
            m_valid = 1'b1;
        end else if (!loadn) begin
            m_m = m_t;
            m_t = m_s;
            m_s = (int'(digit) > 9) ? 9 : int'(digit);
        end else if (enable) begin
            if (m_s > 0) begin
                m_s = m_s - 1;
            end else if (m_t > 0) begin
                m_s = 9;
                m_t = m_t - 1;
            end else if (m_m > 0) begin
                m_s = 9;
                m_t = 5;
                m_m = m_m - 1;
            end
        end
        #1;
        if (m_valid) begin
            chk("model_min", minutes, m_m);
            chk("model_tens", tens_secs, m_t);
            chk("model_secs", secs, m_s);
            chk("model_done", timer_done,
                (m_m == 0 && m_t == 0 && m_s == 0));
        end
    end

    task automatic cyc(input logic c, input logic ln, input logic en,
                       input logic [3:0] d, input int n);
        clear  = c;
        loadn  = ln;
        enable = en;
        digit  = d;
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic lit(input string name, input int m, input int t,
                       input int s, input int done);
        chk({name, "_min"}, minutes, m);
        chk({name, "_tens"}, tens_secs, t);
        chk({name, "_secs"}, secs, s);
        chk({name, "_done"}, timer_done, done);
    endtask

    initial begin
        @(posedge CLK);
        #2;
        lit("reset", 0, 0, 0, 1);

        cyc(0, 0, 0, 4'd2, 1);
        lit("ld2", 0, 0, 2, 0);
        cyc(0, 0, 0, 4'd1, 1);
        lit("ld1", 0, 2, 1, 0);
        cyc(0, 0, 0, 4'd7, 1);
        lit("ld7", 2, 1, 7, 0);
        cyc(0, 0, 0, 4'd9, 1);
        lit("ld9", 1, 7, 9, 0);

        cyc(0, 1, 1, 4'd0, 1);
        lit("cnt1", 1, 7, 8, 0);
        cyc(0, 1, 1, 4'd0, 9);
        lit("cnt10", 1, 6, 9, 0);
        cyc(0, 1, 1, 4'd0, 128);
        lit("cnt138", 0, 0, 1, 0);
        cyc(0, 1, 1, 4'd0, 1);
        lit("cnt139", 0, 0, 0, 1);
        cyc(0, 1, 1, 4'd0, 300);
        lit("hold0", 0, 0, 0, 1);

        cyc(0, 0, 0, 4'd1, 1);
        cyc(0, 0, 0, 4'd0, 2);
        lit("ld100", 1, 0, 0, 0);
        cyc(0, 1, 1, 4'd0, 1);
        lit("brw_min", 0, 5, 9, 0);
        cyc(0, 0, 0, 4'd0, 1);
        cyc(0, 0, 0, 4'd1, 1);
        cyc(0, 0, 0, 4'd0, 1);
        lit("ld010", 0, 1, 0, 0);
        cyc(0, 1, 1, 4'd0, 1);
        lit("brw_tens", 0, 0, 9, 0);

        cyc(0, 1, 0, 4'd5, 5);
        lit("hold_en0", 0, 0, 9, 0);
        cyc(0, 1, 1, 4'd0, 3);
        lit("cnt3", 0, 0, 6, 0);
        cyc(1, 1, 1, 4'd0, 1);
        lit("clr_cnt", 0, 0, 0, 1);
        cyc(0, 0, 0, 4'd4, 2);
        cyc(1, 0, 0, 4'd8, 1);
        lit("clr_ld", 0, 0, 0, 1);

        cyc(0, 0, 0, 4'hC, 1);
        lit("clamp", 0, 0, 9, 0);
        cyc(0, 0, 1, 4'd3, 1);
        lit("ld_over_cnt", 0, 9, 3, 0);
        cyc(0, 1, 1, 4'd0, 1);
        lit("tens9_cnt", 0, 9, 2, 0);
        cyc(0, 1, 1, 4'd0, 3);
        lit("tens9_brw", 0, 8, 9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
